// File: rtl/adsr_envelope_gen.sv
// Linear ADSR envelope generator producing a 7-bit amplitude for the wave generators.
// Gate edges retarget the state machine; amplitude steps only on sample_tick.
module adsr_envelope_gen #(
    parameter int MAX_AMP = 127,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_tick,
    input  logic             gate,
    input  logic [LEN_W-1:0] attack_len,
    input  logic [LEN_W-1:0] decay_len,
    input  logic [6:0]       sustain_level,
    input  logic [LEN_W-1:0] release_len,
    output logic [6:0]       amplitude,
    output logic             busy,
    output logic [2:0]       env_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [6:0] PEAK = 7'(MAX_AMP);

    state_t           state, state_nxt;
    logic [6:0]       amp, amp_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic             gate_p0, gate_p1;
    logic             rise, fall;
    logic [6:0]       sus_tgt;
    logic [LEN_W-1:0] len;
    logic             len_zero, step_due;
    logic [6:0]       amp_up, amp_dn_sus, amp_dn_zero;

    function automatic logic [6:0] sat_inc(input logic [6:0] a, input logic [6:0] lim);
        return (a >= lim) ? lim : a + 7'd1;
    endfunction

    function automatic logic [6:0] sat_dec(input logic [6:0] a, input logic [6:0] lim);
        return (a <= lim) ? lim : a - 7'd1;
    endfunction

    // gate is captured once, then compared with its previous sample
    assign rise = gate_p0 & ~gate_p1;
    assign fall = ~gate_p0 & gate_p1;

    assign sus_tgt = (sustain_level > PEAK) ? PEAK : sustain_level;

    always_comb begin
        case (state)
            ATTACK:  len = attack_len;
            DECAY:   len = decay_len;
            RELEASE: len = release_len;
            default: len = '0;
        endcase
    end

    assign len_zero    = (len == '0);
    assign step_due    = (cnt >= len - LEN_W'(1));
    assign amp_up      = sat_inc(amp, PEAK);
    assign amp_dn_sus  = sat_dec(amp, sus_tgt);
    assign amp_dn_zero = sat_dec(amp, 7'd0);

    always_comb begin
        state_nxt = state;
        amp_nxt   = amp;
        cnt_nxt   = cnt;
        // gate events win over a coincident tick: no step on that clk
        if (rise && (state == IDLE || state == RELEASE)) begin
            state_nxt = ATTACK;
            cnt_nxt   = '0;
        end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
        end else if (sample_tick) begin
            case (state)
                IDLE: amp_nxt = '0;
                ATTACK: begin
                    if (amp >= PEAK) begin
                        state_nxt = DECAY;
                        cnt_nxt   = '0;
                    end else if (len_zero) begin
                        amp_nxt   = PEAK;
                        state_nxt = DECAY;
                        cnt_nxt   = '0;
                    end else if (step_due) begin
                        amp_nxt = amp_up;
                        cnt_nxt = '0;
                        if (amp_up == PEAK) state_nxt = DECAY;
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
                DECAY: begin
                    if (amp <= sus_tgt) begin
                        state_nxt = SUSTAIN;
                        cnt_nxt   = '0;
                    end else if (len_zero) begin
                        amp_nxt   = sus_tgt;
                        state_nxt = SUSTAIN;
                        cnt_nxt   = '0;
                    end else if (step_due) begin
                        amp_nxt = amp_dn_sus;
                        cnt_nxt = '0;
                        if (amp_dn_sus == sus_tgt) state_nxt = SUSTAIN;
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
                SUSTAIN: amp_nxt = sus_tgt;
                RELEASE: begin
                    if (amp == 7'd0) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (len_zero) begin
                        amp_nxt   = '0;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (step_due) begin
                        amp_nxt = amp_dn_zero;
                        cnt_nxt = '0;
                        if (amp_dn_zero == 7'd0) state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    amp_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            amp     <= '0;
            cnt     <= '0;
            gate_p0 <= 1'b0;
            gate_p1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            amp     <= amp_nxt;
            cnt     <= cnt_nxt;
            gate_p0 <= gate;
            gate_p1 <= gate_p0;
        end
    end

    assign amplitude = amp;
    assign busy      = (state != IDLE);
    assign env_state = state;

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Bench for adsr_envelope_gen: two instances (peak 127 and peak 100) share one stimulus,
// a per-lane behavioural envelope model is compared every cycle, plus literal spot values.
module tb_adsr_envelope_gen;

    localparam int LEN_W = 16;
    localparam int PH_IDLE = 0, PH_ATK = 1, PH_DEC = 2, PH_SUS = 3, PH_REL = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             gate;
    logic [LEN_W-1:0] attack_len, decay_len, release_len;
    logic [6:0]       sustain_level;
    logic [6:0]       amp_a, amp_b;
    logic             busy_a, busy_b;
    logic [2:0]       state_a, state_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    int m_amp[2];
    int m_ph[2];
    int m_acc[2];
    bit g1, g2;

    always #5 clk = ~clk;

    adsr_envelope_gen #(.MAX_AMP(127), .LEN_W(LEN_W)) u_a (
        .clk(clk), .rst(rst), .sample_tick(tick), .gate(gate),
        .attack_len(attack_len), .decay_len(decay_len),
        .sustain_level(sustain_level), .release_len(release_len),
        .amplitude(amp_a), .busy(busy_a), .env_state(state_a)
    );

    adsr_envelope_gen #(.MAX_AMP(100), .LEN_W(LEN_W)) u_b (
        .clk(clk), .rst(rst), .sample_tick(tick), .gate(gate),
        .attack_len(attack_len), .decay_len(decay_len),
        .sustain_level(sustain_level), .release_len(release_len),
        .amplitude(amp_b), .busy(busy_b), .env_state(state_b)
    );

    function automatic int peak(input int i);
        return (i == 0) ? 127 : 100;
    endfunction

    // Model: each active phase walks amplitude one unit toward its target every len ticks;
    // a phase whose target is already met hands over to the next phase on the tick.
    always @(posedge clk) begin : model
        bit up, dn, done;
        int tgt, len, s, dir;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_amp[i] = 0; m_ph[i] = PH_IDLE; m_acc[i] = 0;
            end
            g1 = 1'b0; g2 = 1'b0;
        end else begin
            up = g1 && !g2;
            dn = !g1 && g2;
            for (int i = 0; i < 2; i++) begin
                s = (int'(sustain_level) > peak(i)) ? peak(i) : int'(sustain_level);
                if (up && (m_ph[i] == PH_IDLE || m_ph[i] == PH_REL)) begin
                    m_ph[i] = PH_ATK; m_acc[i] = 0;
                end else if (dn && m_ph[i] >= PH_ATK && m_ph[i] <= PH_SUS) begin
                    m_ph[i] = PH_REL; m_acc[i] = 0;
                end else if (tick) begin
                    if (m_ph[i] == PH_IDLE) m_amp[i] = 0;
                    else if (m_ph[i] == PH_SUS) m_amp[i] = s;
                    else begin
                        tgt = (m_ph[i] == PH_ATK) ? peak(i) : (m_ph[i] == PH_DEC) ? s : 0;
                        len = (m_ph[i] == PH_ATK) ? int'(attack_len) :
                              (m_ph[i] == PH_DEC) ? int'(decay_len) : int'(release_len);
                        dir = (m_ph[i] == PH_ATK) ? 1 : -1;
                        done = (dir > 0) ? (m_amp[i] >= tgt) : (m_amp[i] <= tgt);
                        if (!done) begin
                            if (len == 0) m_amp[i] = tgt;
                            else begin
                                m_acc[i]++;
                                if (m_acc[i] >= len) begin
                                    m_amp[i] += dir; m_acc[i] = 0;
                                end
                            end
                        end
                        if ((dir > 0) ? (m_amp[i] >= tgt) : (m_amp[i] <= tgt)) begin
                            m_ph[i] = (m_ph[i] == PH_ATK) ? PH_DEC : (m_ph[i] == PH_DEC) ? PH_SUS : PH_IDLE;
                            m_acc[i] = 0;
                        end
                    end
                end
            end
            g2 = g1;
            g1 = gate;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_amp_a",   amp_a,   m_amp[0]);
            check("model_state_a", state_a, m_ph[0]);
            check("model_busy_a",  busy_a,  m_ph[0] != PH_IDLE);
            check("model_amp_b",   amp_b,   m_amp[1]);
            check("model_state_b", state_b, m_ph[1]);
            check("model_busy_b",  busy_b,  m_ph[1] != PH_IDLE);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_once();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick_once();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not end, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; gate = 1'b0; tick = 1'b0;
        attack_len = 16'd1; decay_len = 16'd2; release_len = 16'd4; sustain_level = 7'd64;
        idle(3);
        chk_en = 1'b1;
        check("reset_amp", amp_a, 0);
        check("reset_state", state_a, 0);
        check("reset_busy", busy_a, 0);

        // idle with gate low
        rst = 1'b1;
        tick_n(100);
        check("idle_amp", amp_a, 0);
        check("idle_busy", busy_a, 0);

        // attack to peak, decay to sustain
        gate = 1'b1;
        idle(3);
        tick_n(127);
        check("attack_peak_amp", amp_a, 127);
        check("attack_peak_state", state_a, 2);
        tick_n(126);
        check("decay_amp", amp_a, 64);
        check("decay_state", state_a, 3);
        check("decay_amp_b", amp_b, 64);

        // release at 4 samples per step
        gate = 1'b0;
        idle(3);
        check("release_state", state_a, 4);
        tick_n(255);
        check("release_last_amp", amp_a, 1);
        tick_once();
        check("release_end_amp", amp_a, 0);
        check("release_end_state", state_a, 0);
        check("release_end_busy", busy_a, 0);

        // retrigger during release keeps amplitude
        gate = 1'b1;
        idle(3);
        tick_n(80);
        check("climb_amp", amp_a, 80);
        gate = 1'b0; release_len = 16'd1;
        idle(3);
        tick_n(40);
        check("rel40_amp", amp_a, 40);
        gate = 1'b1;
        idle(1);
        check("latency_1clk_state", state_a, 4);
        idle(1);
        check("retrig_state", state_a, 1);
        check("retrig_amp", amp_a, 40);
        tick_once();
        check("retrig_step_amp", amp_a, 41);

        // zero lengths jump straight to targets
        attack_len = 16'd0; decay_len = 16'd0; sustain_level = 7'd100;
        tick_once();
        check("zlen_attack_amp", amp_a, 127);
        tick_once();
        check("zlen_decay_amp", amp_a, 100);
        check("zlen_decay_state", state_a, 3);
        sustain_level = 7'd120;
        tick_once();
        check("sustain_follow_amp", amp_a, 120);
        check("sustain_follow_b", amp_b, 100);

        // sustain clamps to peak; fall coincident with tick
        sustain_level = 7'd127;
        tick_once();
        check("clamp_amp_b", amp_b, 100);
        check("clamp_amp_a", amp_a, 127);
        gate = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("coincide_state_b", state_b, 4);
        check("coincide_amp_b", amp_b, 100);
        tick_n(3);
        check("rel_step_b", amp_b, 97);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_amp_b", amp_b, 0);
        check("midrst_state_b", state_b, 0);
        check("midrst_amp_a", amp_a, 0);
        rst = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
